// File: rtl/timer_prog_seq.sv
// Timer programming sequencer: queues timer configuration commands and replays each
// as a disable / preset / enable write burst on the shared bridge port, yielding to the CPU.
module timer_prog_seq #(
   parameter int          DEPTH   = 4,
   parameter logic [31:0] T0_BASE = 32'h0000_7F00,
   parameter logic [31:0] T1_BASE = 32'h0000_7F10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_timer,
   input  logic [31:0] cmd_preset,
   input  logic [1:0]  cmd_mode,
   input  logic        cmd_im,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wd,
   input  logic        cpu_we,
   output logic        cpu_stall,
   output logic [31:0] br_addr,
   output logic [31:0] br_wd,
   output logic        br_we,
   output logic        busy,
   output logic        done,
   output logic        done_timer
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   typedef struct packed {
      logic        timer;
      logic [31:0] preset;
      logic [1:0]  mode;
      logic        im;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIS,
      S_PRE,
      S_ENA
   } state_t;

   cmd_t             fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   cmd_t             cmd_in;
   cmd_t             work;
   state_t           state;
   state_t           next_state;
   logic [31:0]      base;
   logic [31:0]      ctrl_ena;
   logic             seq_fire;

   assign cmd_in    = '{timer: cmd_timer, preset: cmd_preset, mode: cmd_mode, im: cmd_im};
   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   // The CPU owns the port outright, so even the IDLE pop waits until it lets go.
   assign pop       = (state == S_IDLE) && !empty && !cpu_req;
   assign busy      = !empty || (state != S_IDLE);
   assign cpu_stall = 1'b0;

   assign base     = work.timer ? T1_BASE : T0_BASE;
   assign ctrl_ena = {28'b0, work.im, work.mode, 1'b1};
   assign seq_fire = !cpu_req && (state == S_ENA);

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= cmd_in;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         work  <= '0;
      end else begin
         state <= next_state;
         if (pop) begin
            work <= fifo_mem[rd_ptr];
         end
      end
   end

   // done lands the cycle after the enable write, when the FSM is back in IDLE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         done       <= 1'b0;
         done_timer <= 1'b0;
      end else begin
         done <= seq_fire;
         if (seq_fire) begin
            done_timer <= work.timer;
         end
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: if (pop)      next_state = S_DIS;
         S_DIS:  if (!cpu_req) next_state = S_PRE;
         S_PRE:  if (!cpu_req) next_state = S_ENA;
         S_ENA:  if (!cpu_req) next_state = S_IDLE;
         default:              next_state = S_IDLE;
      endcase
   end

   always_comb begin
      br_addr = cpu_addr;
      br_wd   = cpu_wd;
      br_we   = 1'b0;
      if (cpu_req) begin
         br_we = cpu_we;
      end else begin
         unique case (state)
            S_DIS: begin
               br_addr = base;
               br_wd   = 32'h0;
               br_we   = 1'b1;
            end
            S_PRE: begin
               br_addr = base + 32'd4;
               br_wd   = work.preset;
               br_we   = 1'b1;
            end
            S_ENA: begin
               br_addr = base;
               br_wd   = ctrl_ena;
               br_we   = 1'b1;
            end
            default: begin
               br_we = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_prog_seq.sv
// Directed testbench for timer_prog_seq: single command, back-to-back, CPU priority,
// FIFO overflow and mid-sequence reset, all against hand-computed bus traffic.
module tb_timer_prog_seq;

   logic        CLK;
   logic        RST;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_timer;
   logic [31:0] cmd_preset;
   logic [1:0]  cmd_mode;
   logic        cmd_im;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wd;
   logic        cpu_we;
   logic        cpu_stall;
   logic [31:0] br_addr;
   logic [31:0] br_wd;
   logic        br_we;
   logic        busy;
   logic        done;
   logic        done_timer;

   int total = 0;
   int bad   = 0;

   logic [31:0] cap_addr [$];
   logic [31:0] cap_wd   [$];
   int          cap_cyc  [$];
   int          done_cyc [$];
   logic        done_tmr [$];

   timer_prog_seq #(.DEPTH(4), .T0_BASE(32'h0000_7F00), .T1_BASE(32'h0000_7F10)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_timer(cmd_timer),
      .cmd_preset(cmd_preset), .cmd_mode(cmd_mode), .cmd_im(cmd_im),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we),
      .cpu_stall(cpu_stall), .br_addr(br_addr), .br_wd(br_wd), .br_we(br_we),
      .busy(busy), .done(done), .done_timer(done_timer)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Inputs change 1ns after the rising edge; outputs are sampled 1ns later still.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_cmd(input logic v, input logic t, input logic [31:0] p,
                          input logic [1:0] m, input logic i);
      cmd_valid  = v;
      cmd_timer  = t;
      cmd_preset = p;
      cmd_mode   = m;
      cmd_im     = i;
   endtask

   task automatic run_capture(input int n);
      cap_addr.delete(); cap_wd.delete(); cap_cyc.delete();
      done_cyc.delete(); done_tmr.delete();
      for (int i = 0; i < n; i++) begin
         #1;
         if (br_we) begin
            cap_addr.push_back(br_addr);
            cap_wd.push_back(br_wd);
            cap_cyc.push_back(i);
         end
         if (done) begin
            done_cyc.push_back(i);
            done_tmr.push_back(done_timer);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      set_cmd(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
      cpu_req = 1'b0; cpu_addr = 32'h0; cpu_wd = 32'h0; cpu_we = 1'b0;
      tick();
      tick();
      #1;
      total++;
      if ({br_we, br_addr, br_wd, done, done_timer, busy, cmd_ready, cpu_stall} !==
          {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got we=%b addr=%h wd=%h done=%b dt=%b busy=%b rdy=%b stall=%b want 0 0 0 0 0 0 1 0",
                  br_we, br_addr, br_wd, done, done_timer, busy, cmd_ready, cpu_stall);
      end
      RST = 1'b0;
   endtask

   task automatic test_single();
      tick();
      set_cmd(1'b1, 1'b0, 32'd5, 2'b00, 1'b1);
      #1;
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL single_ready: got %b want 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      #1;
      total++;
      if ({busy, br_we} !== 2'b10) begin
         bad++; $display("[TB] FAIL single_queued: got busy=%b we=%b want busy=1 we=0", busy, br_we);
      end
      tick(); #1;
      total++;
      if ({br_we, br_addr, br_wd} !== {1'b1, 32'h7F00, 32'h0}) begin
         bad++; $display("[TB] FAIL single_dis: got we=%b addr=%h wd=%h want 1 00007f00 00000000", br_we, br_addr, br_wd);
      end
      tick(); #1;
      total++;
      if ({br_we, br_addr, br_wd} !== {1'b1, 32'h7F04, 32'h5}) begin
         bad++; $display("[TB] FAIL single_pre: got we=%b addr=%h wd=%h want 1 00007f04 00000005", br_we, br_addr, br_wd);
      end
      tick(); #1;
      total++;
      if ({br_we, br_addr, br_wd} !== {1'b1, 32'h7F00, 32'h9}) begin
         bad++; $display("[TB] FAIL single_ena: got we=%b addr=%h wd=%h want 1 00007f00 00000009", br_we, br_addr, br_wd);
      end
      tick(); #1;
      total++;
      if ({done, done_timer, br_we, busy} !== 4'b1000) begin
         bad++; $display("[TB] FAIL single_done: got done=%b dt=%b we=%b busy=%b want 1 0 0 0", done, done_timer, br_we, busy);
      end
      tick(); #1;
      total++;
      if ({done, busy} !== 2'b00) begin
         bad++; $display("[TB] FAIL single_after: got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_addr [6] = '{32'h7F00, 32'h7F04, 32'h7F00, 32'h7F10, 32'h7F14, 32'h7F10};
      logic [31:0] exp_wd   [6] = '{32'h0, 32'h5, 32'h9, 32'h0, 32'h7, 32'hB};
      int          exp_cyc  [6] = '{0, 1, 2, 4, 5, 6};
      tick();
      set_cmd(1'b1, 1'b0, 32'd5, 2'b00, 1'b1);
      tick();
      set_cmd(1'b1, 1'b1, 32'd7, 2'b01, 1'b1);
      tick();
      cmd_valid = 1'b0;
      run_capture(10);
      total++;
      if (cap_addr.size() != 6) begin
         bad++; $display("[TB] FAIL b2b_count: got %0d writes want 6", cap_addr.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (cap_addr[i] !== exp_addr[i] || cap_wd[i] !== exp_wd[i] || cap_cyc[i] != exp_cyc[i]) begin
               bad++;
               $display("[TB] FAIL b2b_write%0d: got addr=%h wd=%h cyc=%0d want addr=%h wd=%h cyc=%0d",
                        i, cap_addr[i], cap_wd[i], cap_cyc[i], exp_addr[i], exp_wd[i], exp_cyc[i]);
            end
         end
      end
      total++;
      if (done_cyc.size() != 2) begin
         bad++; $display("[TB] FAIL b2b_done_count: got %0d pulses want 2", done_cyc.size());
      end else begin
         total++;
         if (done_cyc[0] != 3 || done_cyc[1] != 7 || done_tmr[0] !== 1'b0 || done_tmr[1] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_done: got cyc=%0d,%0d timer=%b,%b want cyc=3,7 timer=0,1",
                     done_cyc[0], done_cyc[1], done_tmr[0], done_tmr[1]);
         end
      end
   endtask

   task automatic test_cpu_priority();
      tick();
      set_cmd(1'b1, 1'b1, 32'h55, 2'b10, 1'b0);
      tick();
      cmd_valid = 1'b0;
      tick(); #1;
      total++;
      if ({br_we, br_addr, br_wd} !== {1'b1, 32'h7F10, 32'h0}) begin
         bad++; $display("[TB] FAIL cpu_dis: got we=%b addr=%h wd=%h want 1 00007f10 00000000", br_we, br_addr, br_wd);
      end
      tick();
      cpu_req = 1'b1; cpu_addr = 32'h7F14; cpu_wd = 32'h3; cpu_we = 1'b1;
      #1;
      total++;
      if ({br_we, br_addr, br_wd, cpu_stall} !== {1'b1, 32'h7F14, 32'h3, 1'b0}) begin
         bad++; $display("[TB] FAIL cpu_write: got we=%b addr=%h wd=%h stall=%b want 1 00007f14 00000003 0",
                         br_we, br_addr, br_wd, cpu_stall);
      end
      tick();
      cpu_req = 1'b0; cpu_addr = 32'h0; cpu_wd = 32'h0; cpu_we = 1'b0;
      #1;
      total++;
      if ({br_we, br_addr, br_wd} !== {1'b1, 32'h7F14, 32'h55}) begin
         bad++; $display("[TB] FAIL cpu_pre_delayed: got we=%b addr=%h wd=%h want 1 00007f14 00000055", br_we, br_addr, br_wd);
      end
      tick(); #1;
      total++;
      if ({br_we, br_addr, br_wd} !== {1'b1, 32'h7F10, 32'h5}) begin
         bad++; $display("[TB] FAIL cpu_ena: got we=%b addr=%h wd=%h want 1 00007f10 00000005", br_we, br_addr, br_wd);
      end
      tick(); #1;
      total++;
      if ({done, done_timer} !== 2'b11) begin
         bad++; $display("[TB] FAIL cpu_done: got done=%b dt=%b want 1 1", done, done_timer);
      end
   endtask

   task automatic test_fifo_full();
      logic [31:0] exp_addr [12] = '{32'h7F00, 32'h7F04, 32'h7F00, 32'h7F10, 32'h7F14, 32'h7F10,
                                     32'h7F00, 32'h7F04, 32'h7F00, 32'h7F10, 32'h7F14, 32'h7F10};
      logic [31:0] exp_wd   [12] = '{32'h0, 32'h0,  32'h1, 32'h0, 32'h11, 32'h3,
                                     32'h0, 32'h12, 32'hD, 32'h0, 32'h13, 32'hF};
      logic        exp_tmr  [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  kk;
      tick();
      cpu_req = 1'b1; cpu_addr = 32'h0; cpu_wd = 32'h0; cpu_we = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         kk = 3'(k);
         set_cmd(1'b1, kk[0], (k == 0) ? 32'h0 : 32'h10 + 32'(k), kk[1:0], kk[1]);
         #1;
         total++;
         if (cmd_ready !== (k < 4)) begin
            bad++; $display("[TB] FAIL full_ready%0d: got %b want %b", k, cmd_ready, (k < 4));
         end
      end
      tick();
      cmd_valid = 1'b0;
      #1;
      total++;
      if ({cmd_ready, busy, br_we} !== 3'b010) begin
         bad++; $display("[TB] FAIL full_blocked: got rdy=%b busy=%b we=%b want 0 1 0", cmd_ready, busy, br_we);
      end
      cpu_req = 1'b0;
      run_capture(20);
      total++;
      if (cap_addr.size() != 12) begin
         bad++; $display("[TB] FAIL full_write_count: got %0d want 12", cap_addr.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            total++;
            if (cap_addr[i] !== exp_addr[i] || cap_wd[i] !== exp_wd[i]) begin
               bad++;
               $display("[TB] FAIL full_write%0d: got addr=%h wd=%h want addr=%h wd=%h",
                        i, cap_addr[i], cap_wd[i], exp_addr[i], exp_wd[i]);
            end
         end
      end
      total++;
      if (done_cyc.size() != 4) begin
         bad++; $display("[TB] FAIL full_done_count: got %0d want 4", done_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (done_tmr[i] !== exp_tmr[i]) begin
               bad++; $display("[TB] FAIL full_done_timer%0d: got %b want %b", i, done_tmr[i], exp_tmr[i]);
            end
         end
      end
      #1;
      total++;
      if ({cmd_ready, busy} !== 2'b10) begin
         bad++; $display("[TB] FAIL full_drained: got rdy=%b busy=%b want 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      set_cmd(1'b1, 1'b0, 32'hA, 2'b01, 1'b0);
      tick();
      set_cmd(1'b1, 1'b1, 32'hB, 2'b10, 1'b1);
      tick();
      set_cmd(1'b1, 1'b0, 32'hC, 2'b11, 1'b1);
      tick();
      cmd_valid = 1'b0;
      tick(); #1;
      total++;
      if ({br_we, br_addr, br_wd} !== {1'b1, 32'h7F00, 32'h3}) begin
         bad++; $display("[TB] FAIL rst_ena: got we=%b addr=%h wd=%h want 1 00007f00 00000003", br_we, br_addr, br_wd);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      total++;
      if ({br_we, busy, cmd_ready, done} !== 4'b0010) begin
         bad++; $display("[TB] FAIL rst_after: got we=%b busy=%b rdy=%b done=%b want 0 0 1 0", br_we, busy, cmd_ready, done);
      end
      run_capture(10);
      total++;
      if (cap_addr.size() != 0 || done_cyc.size() != 0) begin
         bad++; $display("[TB] FAIL rst_discard: got %0d writes %0d dones want 0 0", cap_addr.size(), done_cyc.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_cpu_priority();
      test_fifo_full();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_prog_seq.md
Name: timer_prog_seq

Overview:
- Hardware sequencer that programs the two bridge-mapped timers (TIMER0 at 0x7F00, TIMER1 at 0x7F10) without CPU involvement.
- Queues timer-configuration commands in a small FIFO and replays each one as a safe three-write bus sequence: disable CTRL, write PRESET, write enabled CTRL.
- Sits between the CPU data-side bridge port and the Bridge. It shares that port with the CPU, and the CPU has strict priority.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- T0_BASE, 32'h00007F00, TIMER0 register base.
- T1_BASE, 32'h00007F10, TIMER1 register base.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_timer  in  1  0 = TIMER0, 1 = TIMER1.
- cmd_preset  in  32  PRESET value.
- cmd_mode  in  2  timer mode field, CTRL[2:1].
- cmd_im  in  1  interrupt mask, CTRL[3].
- cpu_req  in  1  CPU drives a bridge access (read or write) this cycle.
- cpu_addr  in  32  CPU bridge address.
- cpu_wd  in  32  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_stall  out  1  CPU access not performed this cycle; always 0 by design (CPU priority), kept for future policy.
- br_addr  out  32  to Bridge CPU_Addr.
- br_wd  out  32  to Bridge CPU_WD.
- br_we  out  1  to Bridge DEV_WE.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- done  out  1  one-cycle pulse after the final ENA write of a command.
- done_timer  out  1  timer id of the completed command; valid while done=1.

Behaviour:
- Reset, checked at the edge:
  - FIFO emptied, FSM to IDLE.
  - Outputs: br_we=0, br_addr=0, br_wd=0, done=0, done_timer=0, busy=0, cmd_ready=1, cpu_stall=0.
  - A reset mid-sequence abandons the command; partial timer state is left as written.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop when the FSM leaves IDLE.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Push while full is ignored and does not corrupt entries.
- FSM states: IDLE -> DIS -> PRE -> ENA -> IDLE.
  - IDLE: if the FIFO is non-empty, latch the head into a working register, pop, go to DIS.
  - DIS: write base+0 = 32'h0.
  - PRE: write base+4 = preset.
  - ENA: write base+0 = {28'b0, im, mode, 1'b1}.
  - base = T1_BASE if the timer bit is 1, else T0_BASE.
- Bus mux (combinational outputs, registered FSM):
  - If cpu_req=1: br_addr=cpu_addr, br_wd=cpu_wd, br_we=cpu_we. The FSM holds its state and no sequencer write occurs.
  - Else, if the FSM is in DIS/PRE/ENA: drive that state's write with br_we=1 and advance one state per cycle.
  - Else (idle, no CPU request): br_addr=cpu_addr, br_wd=cpu_wd, br_we=0.
- Latency and throughput:
  - An uncontended command takes 4 cycles from IDLE pop to done: pop cycle plus 3 writes.
  - done is asserted the cycle after the ENA write.
  - Back-to-back commands: IDLE is re-entered for one cycle between commands.
- A command whose preset is 0 is still issued unchanged.
- Timer interrupts are not observed; the HWInt path is untouched.

Test Plan:
- Reset, then push {timer=0, preset=5, mode=0, im=1} with cpu_req=0. Required:
  - Writes (0x7F00, 0), (0x7F04, 5), (0x7F00, 0x9) on consecutive cycles.
  - done=1, done_timer=0 the next cycle; busy=0 afterwards.
- Push TIMER0 {preset=5, mode=0, im=1} then TIMER1 {preset=7, mode=1, im=1} back-to-back. Required:
  - Six writes in order, the last being (0x7F10, 0xB).
  - One idle cycle between the two sequences; two done pulses.
- Hold cpu_req=1 with a CPU write (0x7F14, 3) during the PRE state. Required:
  - The bridge sees the CPU write.
  - The sequencer's PRE write is delayed one cycle with values unchanged, then completes.
- Push DEPTH+1 commands with the FSM blocked by cpu_req=1. Required:
  - cmd_ready=0 after the 4th command; the 5th is dropped.
  - After release, exactly 4 sequences run in FIFO order.
- Assert RST during the ENA state. Required:
  - br_we=0 the next cycle, busy=0, cmd_ready=1, no done pulse.
  - The queued remaining commands are discarded.
